// File: rtl/restador_serial.sv
// Digit-serial subtractor: diff = a - b - bin, one 4-bit digit per clock, LSB first.
// Operands are shifted right each RUN cycle; result digits enter the accumulator from the top.
module restador_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rs_a,
  input  logic [WIDTH-1:0] rs_b,
  input  logic             rs_bin,
  input  logic             rs_in_valid,
  output logic             rs_in_ready,
  output logic [WIDTH-1:0] rs_diff,
  output logic             rs_bout,
  output logic             rs_ovf,
  output logic             rs_zero,
  output logic             rs_out_valid,
  input  logic             rs_out_ready
);

  localparam int unsigned NDIG = WIDTH / 4;
  localparam int unsigned CW   = $clog2(NDIG) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nx;
  logic             w_accept;
  logic             w_last;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_brw;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_acc;
  logic [4:0]       w_sub;
  logic [WIDTH-1:0] w_full;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  // Current digit difference; bit 4 is the borrow into the next digit.
  assign w_sub  = {1'b0, r_a[3:0]} - {1'b0, r_b[3:0]} - 5'(r_brw);
  assign w_full = (r_acc >> 4) | (WIDTH'(w_sub[3:0]) << (WIDTH - 4));
  assign w_last = (r_cnt == CW'(NDIG - 1));

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (rs_in_valid && r_in_ready) begin
          w_state_nx = RUN;
          w_accept   = 1'b1;
        end
      end
      RUN:     if (w_last) w_state_nx = DONE;
      DONE:    if (rs_out_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // State register with handshake flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= (w_state_nx == IDLE);
      r_out_valid <= (w_state_nx == DONE);
    end
  end

  // Operand capture, digit iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_brw   <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_acc   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_a     <= rs_a;
      r_b     <= rs_b;
      r_brw   <= rs_bin;
      r_a_msb <= rs_a[WIDTH-1];
      r_b_msb <= rs_b[WIDTH-1];
      r_acc   <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 4;
      r_b   <= r_b >> 4;
      r_brw <= w_sub[4];
      r_acc <= w_full;
      if (w_last) begin
        r_diff <= w_full;
        r_bout <= w_sub[4];
        r_ovf  <= (r_a_msb != r_b_msb) && (w_full[WIDTH-1] != r_a_msb);
        r_zero <= (w_full == '0);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign rs_in_ready  = r_in_ready;
  assign rs_out_valid = r_out_valid;
  assign rs_diff      = r_diff;
  assign rs_bout      = r_bout;
  assign rs_ovf       = r_ovf;
  assign rs_zero      = r_zero;

endmodule

// File: tb/tb_restador_serial.sv
// Directed-vector and random-sweep bench for restador_serial at WIDTH=8 and WIDTH=16.
module tb_restador_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a8, b8, d8;
  logic        bin8, iv8, ir8, bo8, ov8, z8, outv8, outr8;
  logic [15:0] a16, b16, d16;
  logic        bin16, iv16, ir16, bo16, ov16, z16, outv16, outr16;

  int n_checks = 0;
  int n_fail   = 0;

  restador_serial #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .rs_a(a8), .rs_b(b8), .rs_bin(bin8),
    .rs_in_valid(iv8), .rs_in_ready(ir8), .rs_diff(d8), .rs_bout(bo8),
    .rs_ovf(ov8), .rs_zero(z8), .rs_out_valid(outv8), .rs_out_ready(outr8));

  restador_serial #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .rs_a(a16), .rs_b(b16), .rs_bin(bin16),
    .rs_in_valid(iv16), .rs_in_ready(ir16), .rs_diff(d16), .rs_bout(bo16),
    .rs_ovf(ov16), .rs_zero(z16), .rs_out_valid(outv16), .rs_out_ready(outr16));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue one 8-bit op from IDLE, check latency and result, then release it.
  task automatic run8(input vec_t v, input string nm);
    int lat;
    chk({nm, " in_ready"}, 32'(ir8), 32'd1);
    a8 = v.a; b8 = v.b; bin8 = v.bin; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; bin8 = ~v.bin;
    lat = 0;
    while (!outv8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'd2);
    chk({nm, " diff"}, 32'(d8), 32'(v.diff));
    chk({nm, " bout"}, 32'(bo8), 32'(v.bout));
    chk({nm, " ovf"},  32'(ov8), 32'(v.ovf));
    chk({nm, " zero"}, 32'(z8),  32'(v.zero));
    outr8 = 1'b1;
    @(posedge clk); #1;
    outr8 = 1'b0;
    chk({nm, " released"}, 32'(outv8), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h3C, 8'hC3, 1'b0, 8'h79, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    a8 = '0; b8 = '0; bin8 = 1'b0; iv8 = 1'b0; outr8 = 1'b0;
    a16 = '0; b16 = '0; bin16 = 1'b0; iv16 = 1'b0; outr16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready",  32'(ir8),   32'd1);
    chk("rst out_valid", 32'(outv8), 32'd0);
    chk("rst diff",      32'(d8),    32'd0);
    chk("rst flags",     32'({bo8, ov8, z8}), 32'd0);
    rst = 1'b0;

    // out_ready in IDLE must be ignored
    outr8 = 1'b1;
    @(posedge clk); #1;
    outr8 = 1'b0;
    chk("idle out_ready", 32'({ir8, outv8}), 32'b10);

    for (int i = 0; i < 9; i++) run8(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while the consumer stalls; new input not taken.
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h22;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("hold out_valid", 32'(outv8), 32'd1);
      chk("hold diff",      32'(d8),    32'h7F);
      chk("hold ovf",       32'(ov8),   32'd1);
      chk("hold in_ready",  32'(ir8),   32'd0);
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    outr8 = 1'b1;
    @(posedge clk); #1;
    outr8 = 1'b0;
    chk("hold release", 32'({ir8, outv8}), 32'b10);
    @(posedge clk); #1;
    chk("hold no accept", 32'({ir8, outv8}), 32'b10);

    // Reset one cycle into RUN aborts the operation.
    a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort out_valid", 32'(outv8), 32'd0);
    chk("abort in_ready",  32'(ir8),   32'd1);
    chk("abort diff",      32'(d8),    32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort stays idle", 32'({ir8, outv8}), 32'b10);
    run8(vecs[4], "post_abort");

    // 16-bit random sweep, back-to-back with the consumer always ready.
    outr16 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] ra, rb;
      logic        rbin;
      logic [16:0] full;
      logic [15:0] ed;
      logic        eovf;
      int          lat;
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (n == 0) begin ra = 16'h8000; rb = 16'h0001; rbin = 1'b0; end
      if (n == 1) begin ra = 16'h1234; rb = 16'h1233; rbin = 1'b1; end
      full = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      ed   = full[15:0];
      eovf = (ra[15] != rb[15]) && (ed[15] != ra[15]);
      if (!ir16) chk("w16 in_ready", 32'(ir16), 32'd1);
      a16 = ra; b16 = rb; bin16 = rbin; iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0; a16 = ~ra; b16 = ~rb;
      lat = 0;
      while (!outv16 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("w16 latency", 32'(lat), 32'd4);
      chk("w16 diff", 32'(d16), 32'(ed));
      chk("w16 flags", 32'({bo16, ov16, z16}), 32'({full[16], eovf, ed == 16'h0}));
      @(posedge clk); #1;
    end
    outr16 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
